// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: AES-128/192/256 round sequencer driving an external round datapath.
// Define AES_DECRYPT_EN to add decrypt_i, which reverses the round-key order.
module aes_round_sequencer #(
    parameter int WIDTH      = 128,
    parameter int MAX_ROUNDS = 14,
    parameter int IDX_W      = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [1:0]                      nr_sel_i,
`ifdef AES_DECRYPT_EN
    input  logic                            decrypt_i,
`endif
    input  logic [WIDTH-1:0]                data_i,
    input  logic [(MAX_ROUNDS+1)*WIDTH-1:0] keys_i,
    output logic                            round_valid_o,
    input  logic                            round_ready_i,
    output logic [WIDTH-1:0]                round_data_o,
    output logic [WIDTH-1:0]                round_key_o,
    output logic [IDX_W-1:0]                round_idx_o,
    output logic                            round_last_o,
    input  logic                            round_result_valid_i,
    input  logic [WIDTH-1:0]                round_result_i,
    output logic [WIDTH-1:0]                data_final_o,
    output logic                            done_o,
    output logic                            busy_o
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_e;
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
    state_e st_q, st_d;
    logic [IDX_W-1:0] cnt_q, cnt_d, nr_q, nr_d;
    logic dec_q, dec_d, dec_in, done_q, done_d;
    logic [WIDTH-1:0] data_q, data_d, state_q, state_d, key_q, key_d, final_q, final_d;
    logic [WIDTH-1:0] key_w [MAX_ROUNDS+1];
`ifdef AES_DECRYPT_EN
    assign dec_in = decrypt_i;
`else
    assign dec_in = 1'b0;
`endif
    for (genvar k = 0; k <= MAX_ROUNDS; k++) begin : g_key
        assign key_w[k] = keys_i[k*WIDTH +: WIDTH];
    end
    // Decryption walks the schedule backwards; index 0 is the whitening key.
    function automatic logic [IDX_W-1:0] key_idx(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] nr,
                                                 input logic dec);
        return dec ? nr - r : r;
    endfunction
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        data_d  = data_q;
        state_d = state_q;
        key_d   = key_q;
        final_d = final_q;
        done_d  = 1'b0;
        case (st_q)
            IDLE: if (start_i && !abort_i) begin
                st_d   = LOAD;
                data_d = data_i;
                dec_d  = dec_in;
                nr_d   = nr_sel_i == 2'b01 ? IDX_W'(12) : nr_sel_i == 2'b10 ? IDX_W'(14) : IDX_W'(10);
            end
            LOAD: if (abort_i) st_d = IDLE;
            else begin
                st_d    = ISSUE;
                cnt_d   = ONE;
                state_d = data_q ^ key_w[key_idx('0, nr_q, dec_q)];
                key_d   = key_w[key_idx(ONE, nr_q, dec_q)];
            end
            ISSUE: if (abort_i) st_d = IDLE;
            else if (round_ready_i) st_d = WAIT;
            WAIT: if (abort_i) st_d = IDLE;
            else if (round_result_valid_i) begin
                state_d = round_result_i;
                if (cnt_q == nr_q) st_d = DONE;
                else begin
                    st_d  = ISSUE;
                    cnt_d = cnt_q + ONE;
                    key_d = key_w[key_idx(cnt_q + ONE, nr_q, dec_q)];
                end
            end
            DONE: begin
                st_d    = IDLE;
                final_d = state_q;
                done_d  = 1'b1;
            end
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            nr_q    <= IDX_W'(10);
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            state_q <= '0;
            key_q   <= '0;
            final_q <= '0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            nr_q    <= nr_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
            data_q  <= data_d;
            state_q <= state_d;
            key_q   <= key_d;
            final_q <= final_d;
        end
    end
    // done_o rises together with the updated data_final_o, one edge after DONE.
    assign round_valid_o = st_q == ISSUE;
    assign round_data_o  = state_q;
    assign round_key_o   = key_q;
    assign round_idx_o   = cnt_q;
    assign round_last_o  = st_q == ISSUE && cnt_q == nr_q;
    assign data_final_o  = final_q;
    assign done_o        = done_q;
    assign busy_o        = st_q != IDLE;
endmodule
